// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// The optional parity feature is enabled by defining RF_PARITY_EN.
package register_file_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_RUN     = 2'd1,
    ST_MAU_ACK = 2'd2
  } rf_state_e;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/register_file_rport.sv
// One CPU read port: zero-register squash, write bypass and registered output.
// With RF_PARITY_EN defined, also flags a parity mismatch on the stored word.
module register_file_rport
  import register_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int MEM_W    = DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [MEM_W-1:0]  rword_i,
  input  logic              wfire_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef RF_PARITY_EN
  output logic              perr_o,
`endif
  output logic [DATA_W-1:0] rdata_o
);

  logic              is_zero, is_byp;
  logic [DATA_W-1:0] rdata_d, rdata_q;

  assign is_zero = (raddr_i == ADDR_W'(ZERO_REG));
  assign is_byp  = wfire_i && (waddr_i == raddr_i);

  always_comb begin
    rdata_d = rdata_q;
    if (en_i) begin
      if (is_zero)     rdata_d = '0;
      else if (is_byp) rdata_d = wdata_i;
      else             rdata_d = rword_i[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

`ifdef RF_PARITY_EN
  // Only words actually taken from storage are checked.
  assign perr_o = en_i && !is_zero && !is_byp && (^rword_i);
`endif

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with clear sweep, bypass and MAU access port.
// Define RF_PARITY_EN to add per-entry even parity and the sticky parity_err output.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 31
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              cpu_clk_en,
  input  logic [NREAD*ADDR_W-1:0] cpu_read_address,
  output logic [NREAD*DATA_W-1:0] cpu_data_read,
  input  logic [ADDR_W-1:0]       cpu_write_address,
  input  logic [DATA_W-1:0]       cpu_data_write,
  input  logic                    cpu_wren,
  input  logic                    alive,
  input  logic                    mau_req,
  input  logic                    mau_wren,
  input  logic [ADDR_W-1:0]       mau_address,
  input  logic [DATA_W-1:0]       mau_data_write,
  output logic                    mau_ack,
  output logic [DATA_W-1:0]       mau_data_read,
`ifdef RF_PARITY_EN
  output logic                    parity_err,
`endif
  output logic                    busy
);

  localparam int DEPTH = rf_depth(ADDR_W);
`ifdef RF_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [DEPTH];
  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] mau_rdata_q, mau_rdata_d;

  logic              cpu_own, rd_en, cpu_wfire, mau_acc, mau_zero;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MEM_W-1:0]  mem_wword;

  assign cpu_own   = (state_q == ST_RUN) && alive;
  assign rd_en     = cpu_own && (|cpu_clk_en);
  assign cpu_wfire = cpu_own && cpu_wren && cpu_clk_en[1] &&
                     (cpu_write_address != ADDR_W'(ZERO_REG));
  assign mau_acc   = (state_q == ST_RUN) && !alive && mau_req;
  assign mau_zero  = (mau_address == ADDR_W'(ZERO_REG));

  // Single storage write port; sweep, CPU and MAU are mutually exclusive by state.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu_write_address;
    mem_wdata = cpu_data_write;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = '0;
    end else if (cpu_wfire) begin
      mem_we    = 1'b1;
    end else if (mau_acc && mau_wren && !mau_zero) begin
      mem_we    = 1'b1;
      mem_waddr = mau_address;
      mem_wdata = mau_data_write;
    end
  end

`ifdef RF_PARITY_EN
  assign mem_wword = {^mem_wdata, mem_wdata};
`else
  assign mem_wword = mem_wdata;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wword;
  end

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    mau_rdata_d = mau_rdata_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mau_acc) begin
          state_d = ST_MAU_ACK;
          if (!mau_wren) mau_rdata_d = mau_zero ? '0 : mem_q[mau_address][DATA_W-1:0];
        end
      end
      ST_MAU_ACK: state_d = ST_RUN;
      default:    state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      mau_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      mau_rdata_q <= mau_rdata_d;
    end
  end

  assign busy          = (state_q == ST_CLEAR);
  assign mau_ack       = (state_q == ST_MAU_ACK);
  assign mau_data_read = mau_rdata_q;

`ifdef RF_PARITY_EN
  logic [NREAD-1:0] port_perr;
`endif

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rport
    register_file_rport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .MEM_W   (MEM_W)
    ) u_rport (
      .clk    (clk),
      .reset_n(reset_n),
      .en_i   (rd_en),
      .raddr_i(cpu_read_address[gi*ADDR_W +: ADDR_W]),
      .rword_i(mem_q[cpu_read_address[gi*ADDR_W +: ADDR_W]]),
      .wfire_i(cpu_wfire),
      .waddr_i(cpu_write_address),
      .wdata_i(cpu_data_write),
`ifdef RF_PARITY_EN
      .perr_o (port_perr[gi]),
`endif
      .rdata_o(cpu_data_read[gi*DATA_W +: DATA_W])
    );
  end

`ifdef RF_PARITY_EN
  logic mau_perr, parity_err_q;
  assign mau_perr = mau_acc && !mau_wren && !mau_zero && (^mem_q[mau_address]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_err_q <= 1'b0;
    else          parity_err_q <= parity_err_q | (|port_perr) | mau_perr;
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized bench for register_file_mp checked every cycle against an array model.
module tb_register_file_mp;
  localparam int DW = 32, AW = 5, NR = 2, ZR = 31, DEPTH = 32;

  logic           clk = 1'b0, reset_n = 1'b0;
  logic [1:0]     cpu_clk_en = '0;
  logic [NR*AW-1:0] cpu_read_address = '0;
  logic [NR*DW-1:0] cpu_data_read;
  logic [AW-1:0]  cpu_write_address = '0;
  logic [DW-1:0]  cpu_data_write = '0;
  logic           cpu_wren = 1'b0, alive = 1'b1;
  logic           mau_req = 1'b0, mau_wren = 1'b0;
  logic [AW-1:0]  mau_address = '0;
  logic [DW-1:0]  mau_data_write = '0;
  logic           mau_ack, busy;
  logic [DW-1:0]  mau_data_read;

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_clk_en(cpu_clk_en),
    .cpu_read_address(cpu_read_address), .cpu_data_read(cpu_data_read),
    .cpu_write_address(cpu_write_address), .cpu_data_write(cpu_data_write),
    .cpu_wren(cpu_wren), .alive(alive), .mau_req(mau_req), .mau_wren(mau_wren),
    .mau_address(mau_address), .mau_data_write(mau_data_write),
    .mau_ack(mau_ack), .mau_data_read(mau_data_read), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: storage as a plain array, observable outputs as variables.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd  [NR] = '{default: '0};
  logic [DW-1:0] m_mrd = '0;
  int            m_clear_left = DEPTH;
  logic          m_ack = 1'b0;
  logic          m_wf;
  logic [AW-1:0] m_idx;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_clear_left = DEPTH;
      m_ack = 1'b0;
      m_mrd = '0;
      for (int p = 0; p < NR; p++) m_rd[p] = '0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (alive) begin
      m_wf = cpu_wren && cpu_clk_en[1] && (cpu_write_address != AW'(ZR));
      if (cpu_clk_en != 2'b00)
        for (int p = 0; p < NR; p++) begin
          m_idx = cpu_read_address[p*AW +: AW];
          if (m_idx == AW'(ZR))                         m_rd[p] = '0;
          else if (m_wf && cpu_write_address == m_idx)  m_rd[p] = cpu_data_write;
          else                                          m_rd[p] = m_mem[m_idx];
        end
      if (m_wf) m_mem[cpu_write_address] = cpu_data_write;
    end else if (mau_req) begin
      m_ack = 1'b1;
      if (mau_wren) begin
        if (mau_address != AW'(ZR)) m_mem[mau_address] = mau_data_write;
      end else begin
        m_mrd = (mau_address == AW'(ZR)) ? '0 : m_mem[mau_address];
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'b0, busy}, {31'b0, m_clear_left > 0});
    check("mau_ack", {31'b0, mau_ack}, {31'b0, m_ack});
    check("mau_data_read", mau_data_read, m_mrd);
    for (int p = 0; p < NR; p++) check("cpu_data_read", cpu_data_read[p*DW +: DW], m_rd[p]);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin step(); n++; end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'(ZR) : AW'($urandom_range(0, DEPTH-1));
  endfunction

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    cpu_read_address[p*AW +: AW] = a;
  endtask

  task automatic mau_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic tog, output int lat);
    mau_req = 1'b1; mau_wren = wr; mau_address = a; mau_data_write = d;
    lat = 0;
    while (!mau_ack && lat < 64) begin step(); lat++; end
    check("mau_ack_seen", {31'b0, mau_ack}, 32'd1);
    mau_req = 1'b0;
    if (tog) alive = ~alive;
    step();
  endtask

  int n, lat;

  initial begin
    repeat (3) step();
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_ack", {31'b0, mau_ack}, 32'd0);
    check("rst_rd0", cpu_data_read[31:0], 32'h0);

    // Clear sweep length and all-zero contents
    reset_n = 1'b1;
    count_busy(n);
    check("busy_len", n, 32'd32);
    cpu_clk_en = 2'b01;
    for (int i = 0; i < DEPTH; i++) begin
      set_ra(0, AW'(i)); set_ra(1, AW'(DEPTH-1-i));
      step();
    end
    check("clr_rd0", cpu_data_read[31:0], 32'h0);
    check("clr_rd1", cpu_data_read[63:32], 32'h0);

    // Bypass
    cpu_clk_en = 2'b10; cpu_wren = 1'b1; cpu_write_address = 5'd3; cpu_data_write = 32'hDEADBEEF;
    set_ra(0, 5'd3); set_ra(1, 5'd7);
    step();
    check("byp_p0", cpu_data_read[31:0], 32'hDEADBEEF);
    check("byp_model", m_rd[0], 32'hDEADBEEF);
    cpu_clk_en = 2'b01; cpu_wren = 1'b0; set_ra(1, 5'd3);
    step();
    check("later_p1", cpu_data_read[63:32], 32'hDEADBEEF);

    // Zero register
    cpu_clk_en = 2'b10; cpu_wren = 1'b1; cpu_write_address = 5'd30; cpu_data_write = 32'h0BADF00D;
    step();
    cpu_write_address = 5'd31; cpu_data_write = 32'h12345678;
    set_ra(0, 5'd31); set_ra(1, 5'd30);
    step();
    check("zr_p0", cpu_data_read[31:0], 32'h0);
    check("r30_p1", cpu_data_read[63:32], 32'h0BADF00D);
    cpu_clk_en = 2'b01; cpu_wren = 1'b0; set_ra(1, 5'd31);
    step();
    check("zr_p1", cpu_data_read[63:32], 32'h0);

    // MAU ownership; CPU writes to r5 must be ignored throughout
    cpu_clk_en = 2'b00; alive = 1'b0;
    step();
    cpu_clk_en = 2'b11; cpu_wren = 1'b1; cpu_write_address = 5'd5; cpu_data_write = 32'h11111111;
    repeat (2) step();
    mau_access(1'b1, 5'd5, 32'hCAFEF00D, 1'b0, lat);
    check("mau_wr_lat", lat, 32'd1);
    mau_access(1'b0, 5'd5, 32'h0, 1'b0, lat);
    check("mau_rd_lat", lat, 32'd1);
    check("mau_rd_r5", mau_data_read, 32'hCAFEF00D);
    cpu_wren = 1'b0; cpu_clk_en = 2'b00;
    step();
    alive = 1'b1; cpu_clk_en = 2'b01; set_ra(0, 5'd5);
    step();
    check("cpu_rd_r5", cpu_data_read[31:0], 32'hCAFEF00D);

    // Random traffic
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 11) == 0) begin
        alive = 1'b0;
        cpu_clk_en = 2'($urandom_range(0, 3)); cpu_wren = 1'($urandom_range(0, 1));
        cpu_write_address = rnd_addr(); cpu_data_write = $urandom;
        step();
        cpu_clk_en = 2'b00; cpu_wren = 1'b0;
        mau_access(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'b1, lat);
        check("mau_lat", lat, 32'd1);
        alive = 1'b1;
      end else begin
        cpu_clk_en = 2'($urandom_range(0, 3)); cpu_wren = 1'($urandom_range(0, 1));
        cpu_write_address = rnd_addr(); cpu_data_write = $urandom;
        for (int p = 0; p < NR; p++)
          set_ra(p, ($urandom_range(0, 2) == 0) ? cpu_write_address : rnd_addr());
        step();
      end
    end

    // Make outputs nonzero, then abort mid-sweep
    cpu_clk_en = 2'b10; cpu_wren = 1'b1; cpu_write_address = 5'd1; cpu_data_write = 32'hA5A5_0001;
    set_ra(0, 5'd1); set_ra(1, 5'd1);
    step();
    cpu_wren = 1'b0; cpu_clk_en = 2'b00; alive = 1'b0;
    step();
    mau_access(1'b1, 5'd2, 32'h55AA55AA, 1'b0, lat);
    mau_access(1'b0, 5'd2, 32'h0, 1'b0, lat);
    check("pre_rst_mau", mau_data_read, 32'h55AA55AA);
    check("pre_rst_rd0", cpu_data_read[31:0], 32'hA5A50001);
    reset_n = 1'b0; #1;
    check("async_rd0", cpu_data_read[31:0], 32'h0);
    check("async_rd1", cpu_data_read[63:32], 32'h0);
    check("async_mau", mau_data_read, 32'h0);
    check("async_busy", {31'b0, busy}, 32'd1);
    step();
    reset_n = 1'b1;
    repeat (10) step();
    reset_n = 1'b0; #1;
    check("mid_busy", {31'b0, busy}, 32'd1);
    step();
    reset_n = 1'b1;
    count_busy(n);
    check("busy_len_restart", n, 32'd32);

    // MAU request held across the sweep
    reset_n = 1'b0;
    step();
    alive = 1'b0; mau_req = 1'b1; mau_wren = 1'b0; mau_address = 5'd0;
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      check("ack_in_clear", {31'b0, mau_ack}, 32'd0);
      step(); n++;
    end
    check("busy_len_mau", n, 32'd32);
    check("ack_first_run", {31'b0, mau_ack}, 32'd0);
    step();
    check("ack_after_run", {31'b0, mau_ack}, 32'd1);
    mau_req = 1'b0;
    step();
    check("ack_dropped", {31'b0, mau_ack}, 32'd0);
    check("mau_rd_r0", mau_data_read, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-read-port CPU register file. Next generation of the two-port register file bank.
- Configurable data width, depth and read-port count. Hardwired zero register. Write-to-read bypass.
- Post-reset hardware clear sweep. Request/acknowledge MAU (debug/loader) access port, used while the core is not alive.
- Sits between decode (read indices) and writeback (write port) in the CPU; the MAU owns it while alive=0.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries
- NREAD, 2, number of CPU read ports (1..4)
- ZERO_REG, 31, index that always reads 0; writes to it are dropped

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_clk_en  in  2  phase enables: bit0 = read phase, bit1 = write phase
- cpu_read_address  in  NREAD*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W]
- cpu_data_read  out  NREAD*DATA_W  packed registered read data
- cpu_write_address  in  ADDR_W  write index
- cpu_data_write  in  DATA_W  write data
- cpu_wren  in  1  write request, qualified by cpu_clk_en[1]
- alive  in  1  1 = CPU owns the file, 0 = MAU owns it
- mau_req  in  1  MAU access request, level-held until mau_ack
- mau_wren  in  1  1 = write, 0 = read; sampled with mau_req
- mau_address  in  ADDR_W  MAU register index
- mau_data_write  in  DATA_W  MAU write data
- mau_ack  out  1  one-cycle completion pulse
- mau_data_read  out  DATA_W  MAU read data; valid while mau_ack=1, held afterwards
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=CLEAR, clr_idx=0, busy=1.
  - All cpu_data_read=0, mau_ack=0, mau_data_read=0.
  - Storage contents are not reset directly.
- FSM states: CLEAR, RUN, MAU_ACK.
- CLEAR:
  - Each cycle writes 0 to entry clr_idx, then increments clr_idx.
  - After the clr_idx==DEPTH-1 write, goes to RUN. busy falls with the RUN entry; DEPTH cycles after reset release.
  - CPU writes are ignored and cpu_data_read stays 0.
  - mau_req stays pending, unacked.
- RUN, alive=1 (CPU ownership):
  - Read: if cpu_clk_en != 0, each port i registers its data, so 1-cycle latency.
  - Read data = 0 if the index is ZERO_REG.
  - Otherwise it is the bypass value cpu_data_write if a CPU write to the same index fires in the same cycle.
  - Otherwise it is mem[index].
  - If cpu_clk_en==0, cpu_data_read holds.
  - Write fires when cpu_wren & cpu_clk_en[1] & (cpu_write_address != ZERO_REG).
  - MAU requests are not serviced and stay pending.
- RUN, alive=0 (MAU ownership):
  - CPU reads and writes are ignored; cpu_data_read holds.
  - If mau_req=1, the request is accepted this cycle and the FSM goes to MAU_ACK.
  - On accept, a write updates mem (unless ZERO_REG); a read latches mem[mau_address] into mau_data_read (0 for ZERO_REG).
- MAU_ACK:
  - mau_ack=1 for exactly one cycle, then return to RUN.
  - mau_req must drop in the ack cycle; if it is still high in the cycle after the ack, that is a new request.
- alive toggling while in MAU_ACK: the accepted access completes and is acked regardless.
- Reset asserted mid-sweep or mid-MAU access: abort; restart CLEAR from 0; no ack issued.
- Multiple read ports on the same index: all receive identical data.

Optional Feature:
- Macro: RF_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed on write (the clear sweep writes parity 0).
  - A parity check runs on every CPU/MAU read.
  - Adds output parity_err (1 bit): sticky, set one cycle after a mismatching read, cleared only by reset.
  - ZERO_REG reads and bypassed reads are never checked.
- Not defined: no parity storage and no parity_err port.

Decomposition:
- Package register_file_pkg: FSM state enum (CLEAR, RUN, MAU_ACK); localparam helper DEPTH from ADDR_W.
- Sub-module register_file_rport:
  - One instance per read port (generate loop over NREAD).
  - Contains the zero-register compare, the bypass compare/mux and the output register with enable.
  - Holds the parity check under RF_PARITY_EN.

Test Plan:
- Reset release -> busy=1 for exactly 32 cycles (default); then a read of every index on both ports returns 0x00000000.
- Write 0xDEADBEEF to r3 (cpu_clk_en=2'b10) while port0 reads r3 in the same cycle -> port0=0xDEADBEEF next cycle (bypass); port1 reads r3 later -> 0xDEADBEEF.
- Write 0x12345678 to r31 -> r31 reads 0x00000000 on all ports; r30 unchanged.
- alive=0: MAU writes r5=0xCAFEF00D, then reads r5 -> each access acked exactly one cycle after acceptance; read returns 0xCAFEF00D; CPU write to r5 during alive=0 has no effect.
- mau_req held during CLEAR -> no ack until busy=0, then ack the cycle after the first RUN cycle.
- Assert reset_n low mid-sweep (clr_idx=10) -> outputs zero immediately; sweep restarts and busy lasts a full 32 cycles after release.
